// File: rtl/priority_decoder.sv
// priority_decoder: buffers 3-bit encoded indices in a small FIFO and replays
// each one as a one-hot byte on `out` for HOLD consecutive clock cycles.
// Successive indices are issued back-to-back with no idle gap.
//
// Build option: define PRIORITY_DECODER_FALLTHRU_EN to let an index that
// arrives while the block is idle with an empty FIFO skip the FIFO. It then
// appears on `out` one edge after acceptance instead of two.
module priority_decoder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned HOLD  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in,
    output logic [7:0]               out,
    output logic                     out_valid,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [CntW-1:0] FullCnt  = CntW'(DEPTH);
    localparam logic [3:0]      HoldLoad = 4'(HOLD - 1);

    typedef enum logic [0:0] {
        StIdle,
        StDrive
    } state_e;

    // FIFO storage and bookkeeping
    logic [2:0]      mem_q [DEPTH];
    logic [2:0]      mem_d [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    // Output FSM state
    state_e          state_q, state_d;
    logic [3:0]      hold_q, hold_d;
    logic [7:0]      out_q, out_d;
    logic            out_valid_q, out_valid_d;

    // Handshake and control strobes
    logic            fifo_empty;
    logic            fifo_full;
    logic            accept;
    logic            bypass;
    logic            push;
    logic            pop;
    logic [2:0]      head;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FullCnt);

    // Readiness depends only on the registered count. A pop on a full FIFO
    // frees its slot for the next cycle, not this one.
    assign in_ready   = !fifo_full;
    assign accept     = in_valid && in_ready;
    assign head       = mem_q[rd_ptr_q];

`ifdef PRIORITY_DECODER_FALLTHRU_EN
    // An idle block with nothing queued loads the offered index straight into the output stage
    assign bypass = accept && (state_q == StIdle) && fifo_empty;
`else
    assign bypass = 1'b0;
`endif

    assign push = accept && !bypass;

    // Output FSM: choose the next index to show and count down its hold time
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        pop         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    state_d     = StDrive;
                    out_d       = 8'h01 << head;
                    out_valid_d = 1'b1;
                    hold_d      = HoldLoad;
                end else if (bypass) begin
                    state_d     = StDrive;
                    out_d       = 8'h01 << in;
                    out_valid_d = 1'b1;
                    hold_d      = HoldLoad;
                end
            end

            StDrive: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - 4'd1;
                end else if (!fifo_empty) begin
                    // Reload on the same edge so consecutive indices leave no gap
                    pop         = 1'b1;
                    out_d       = 8'h01 << head;
                    out_valid_d = 1'b1;
                    hold_d      = HoldLoad;
                end else begin
                    state_d     = StIdle;
                    out_d       = 8'h00;
                    out_valid_d = 1'b0;
                end
            end

            default: begin
                state_d     = StIdle;
                out_d       = 8'h00;
                out_valid_d = 1'b0;
                hold_d      = '0;
            end
        endcase
    end

    // FIFO next state: write at wr_ptr, read at rd_ptr, and track occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = in;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // State register; synchronous reset discards anything queued or being driven
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            out_q       <= 8'h00;
            out_valid_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mem_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_q       <= mem_d;
        end
    end

    assign out        = out_q;
    assign out_valid  = out_valid_q;
    assign fifo_count = count_q;

    // Output invariants: one-hot while valid, zero while idle, never overfull
    a_onehot_when_valid : assert property (@(posedge clk) disable iff (rst)
        out_valid |-> $onehot(out));
    a_zero_when_idle : assert property (@(posedge clk) disable iff (rst)
        !out_valid |-> (out == 8'h00));
    a_count_bound : assert property (@(posedge clk) disable iff (rst)
        fifo_count <= FullCnt);

endmodule

// File: tb/tb_priority_decoder.sv
// Scoreboard bench for priority_decoder. A tracker process queues every
// accepted index, and a monitor process checks each issued pulse against
// that queue for its value and its HOLD-cycle length. Directed sequences
// check latency, back-to-back issue, back-pressure and reset flush.
module tb_priority_decoder;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned HOLD  = 2;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          in_valid = 1'b0;
    logic [2:0]    in_idx   = 3'd0;
    logic          in_ready;
    logic [7:0]    out;
    logic          out_valid;
    logic [CW-1:0] fifo_count;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] exp_q[$];
    int         acc_n  = 0;
    int         phase  = 0;
    logic [2:0] cur    = 3'd0;

    priority_decoder #(
        .DEPTH(DEPTH),
        .HOLD (HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_idx),
        .out       (out),
        .out_valid (out_valid),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for the block to go idle with an empty FIFO, then confirm every accepted index was issued
    task automatic wait_idle(input string name);
        int n = 0;
        while ((out_valid || fifo_count != '0) && n < 200) begin
            tick();
            n++;
        end
        chk({name, "_drain_in_time"}, 32'(n < 200), 32'd1);
        chk({name, "_idle_out_zero"}, 32'(out), 32'h0);
        chk({name, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Tracker: record each handshake; a reset edge discards everything pending
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else if (in_valid && in_ready) begin
            exp_q.push_back(in_idx);
            acc_n++;
        end
    end

    // Monitor: each pulse must match the head of the queue and last exactly HOLD cycles
    always @(negedge clk) begin
        if (rst) begin
            phase = 0;
        end else if (out_valid) begin
            if (phase == 0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue: actual out 0x%0h required no pulse", out);
                end else begin
                    cur = exp_q.pop_front();
                end
            end
            chk("issue_value", 32'(out), 32'(8'h01 << cur));
            phase = (phase + 1 == HOLD) ? 0 : phase + 1;
        end else begin
            chk("idle_out_zero", 32'(out), 32'h0);
            chk("pulse_length", 32'(phase), 32'd0);
            phase = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] seq_exp [8];
        int         cnt_exp [10];
        int         acc_exp;
        int         full_exp;
        int         a0;
        int         n;
        int         nsame;

`ifdef PRIORITY_DECODER_FALLTHRU_EN
        seq_exp  = '{8'h01, 8'h01, 8'h80, 8'h80, 8'h08, 8'h08, 8'h00, 8'h00};
        cnt_exp  = '{0, 1, 1, 2, 2, 3, 3, 4, 3, 4};
        acc_exp  = 9;
        full_exp = 3;
        nsame    = 5;
`else
        seq_exp  = '{8'h00, 8'h01, 8'h01, 8'h80, 8'h80, 8'h08, 8'h08, 8'h00};
        cnt_exp  = '{1, 1, 2, 2, 3, 3, 4, 3, 4, 3};
        acc_exp  = 8;
        full_exp = 4;
        nsame    = 4;
`endif

        // Reset with an offer pending: the offer must be ignored
        rst      = 1'b1;
        in_valid = 1'b1;
        in_idx   = 3'd3;
        tick();
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("reset_out", 32'(out), 32'h0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_fifo_count", 32'(fifo_count), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Single index 5: check latency and hold length
        in_valid = 1'b1;
        in_idx   = 3'd5;
        tick();
        in_valid = 1'b0;
`ifdef PRIORITY_DECODER_FALLTHRU_EN
        chk("single_lat1_valid", 32'(out_valid), 32'd1);
        chk("single_lat1_out", 32'(out), 32'h20);
        chk("single_bypass_count", 32'(fifo_count), 32'd0);
        tick();
        chk("single_hold2_valid", 32'(out_valid), 32'd1);
        tick();
        chk("single_end_valid", 32'(out_valid), 32'd0);
`else
        chk("single_lat1_valid", 32'(out_valid), 32'd0);
        chk("single_queued_count", 32'(fifo_count), 32'd1);
        tick();
        chk("single_lat2_valid", 32'(out_valid), 32'd1);
        chk("single_lat2_out", 32'(out), 32'h20);
        tick();
        chk("single_hold2_valid", 32'(out_valid), 32'd1);
        tick();
        chk("single_end_valid", 32'(out_valid), 32'd0);
`endif
        wait_idle("single");

        // Indices 0, 7, 3 on consecutive cycles: issued back-to-back with no gap
        in_valid = 1'b1;
        in_idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) in_idx = 3'd7;
            if (i == 1) in_idx = 3'd3;
            if (i == 2) in_valid = 1'b0;
            chk($sformatf("b2b_seq_%0d", i), 32'(out), 32'(seq_exp[i]));
        end
        wait_idle("b2b");

        // Offer index 2 for 10 cycles: back-pressure at full, rejected offers not stored
        a0       = acc_n;
        in_valid = 1'b1;
        in_idx   = 3'd2;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("bp_count_%0d", i), 32'(fifo_count), 32'(cnt_exp[i]));
            chk($sformatf("bp_ready_%0d", i), 32'(in_ready), 32'(cnt_exp[i] != 4));
        end
        in_valid = 1'b0;
        chk("bp_accepted", 32'(acc_n - a0), 32'(acc_exp));
        wait_idle("bp");

        // Fill the FIFO, then reset mid-drive: nothing pending may survive
        in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_idx = 3'(i + 1);
            tick();
        end
        chk("flush_prefill_count", 32'(fifo_count), 32'(full_exp));
        chk("flush_prefill_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("flush_out", 32'(out), 32'h0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_fifo_count", 32'(fifo_count), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("flush_no_stale_%0d", i), 32'(out_valid), 32'd0);
        end
        in_valid = 1'b1;
        in_idx   = 3'd6;
        tick();
        in_valid = 1'b0;
        wait_idle("flush");

        // Bring the count to 2, then push and pop on the same edge: count must stay 2
        in_valid = 1'b1;
        for (int i = 0; i < nsame; i++) begin
            in_idx = 3'(i + 1);
            tick();
            if (i >= nsame - 2) begin
                chk($sformatf("same_cycle_count_%0d", i), 32'(fifo_count), 32'd2);
            end
        end
        in_valid = 1'b0;
        wait_idle("same_cycle");

        // 1000 random handshakes: many pointer wraps, order checked by the monitor
        a0 = acc_n;
        n  = 0;
        while ((acc_n - a0) < 1000 && n < 20000) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_idx   = 3'($urandom_range(0, 7));
            tick();
            n++;
        end
        in_valid = 1'b0;
        chk("random_reached_1000", 32'((acc_n - a0) >= 1000), 32'd1);
        wait_idle("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
